// File: rtl/i2s_asrc_pkg.sv
// Shared constants and types for the I2S transmit path.
// The left-justified output format is selected in i2s_tx_serializer with I2S_TX_LJ_EN.
package i2s_asrc_pkg;

    localparam int DATA_W    = 24;
    localparam int SLOT_W    = 32;
    localparam int FRAME_BCK = 64;
    localparam int LOAD_BIT  = 63;
    localparam int BIT_W     = $clog2(FRAME_BCK);

    typedef struct packed {
        logic signed [DATA_W-1:0] left;
        logic signed [DATA_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Small synchronous sample FIFO; dout is registered and valid the cycle after rd.
// Reads of an empty FIFO and writes to a full FIFO (without a same-cycle read) are ignored.
module i2s_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_dout;
    logic             w_rd_en;
    logic             w_wr_en;

    assign w_rd_en = rd && (r_level != '0);
    assign w_wr_en = wr && ((r_level != FULL_LVL) || w_rd_en);

    // Storage array; contents are don't-care once the pointers are reset
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers, occupancy and registered read data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_dout  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = r_dout;
    assign full  = (r_level == FULL_LVL);
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Serialises buffered 24-bit stereo pairs onto a 64-BCK I2S frame.
// Define I2S_TX_LJ_EN for left-justified WS timing; default is Philips I2S.
module i2s_tx_serializer
    import i2s_asrc_pkg::*;
#(
    parameter int BCK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          AMCLK_i,
    input  logic                          ARST_i,
    input  logic signed [DATA_W-1:0]      APSDATA_LEFT_i,
    input  logic signed [DATA_W-1:0]      APSDATA_RIGHT_i,
    input  logic                          APDATA_VALID_i,
    input  logic                          downsample_2x_i,
    input  logic                          STATUS_CLR_i,
    output logic                          I2S_BCK,
    output logic                          I2S_WS,
    output logic                          I2S_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL_o,
    output logic                          UNDERFLOW_o,
    output logic                          OVERFLOW_o
);
    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(LOAD_BIT);
    localparam logic [BIT_W-1:0] BIT_RESET = BIT_W'(LOAD_BIT - 1);

    // WS level for the slot that bit b is about to present
    function automatic logic ws_for_bit(input logic [BIT_W-1:0] b);
`ifdef I2S_TX_LJ_EN
        return (b < BIT_W'(SLOT_W));
`else
        return (b >= BIT_W'(SLOT_W - 1)) && (b != BIT_W'(FRAME_BCK - 1));
`endif
    endfunction

    // Serial bit for slot position b: MSB-first sample, zero padding elsewhere
    function automatic logic data_for_bit(input stereo_t s, input logic [BIT_W-1:0] b);
        logic r;
        r = 1'b0;
        if (b < BIT_W'(DATA_W)) begin
            r = s.left[5'(DATA_W - 1) - b[4:0]];
        end else if ((b >= BIT_W'(SLOT_W)) && (b < BIT_W'(SLOT_W + DATA_W))) begin
            r = s.right[5'(DATA_W - 1) - b[4:0]];
        end
        return r;
    endfunction

    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_bck;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_ws;
    logic                r_data;
    logic                r_phase;
    logic                r_primed;
    logic                r_pop_p1;
    stereo_t             r_hold;
    logic                r_underflow;
    logic                r_overflow;

    logic                w_tick;
    logic                w_fall;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic                w_load;
    logic                w_rd;
    logic                w_wr_req;
    logic                w_wr;
    logic                w_full;
    logic                w_empty;
    logic                w_unf_set;
    logic                w_ovf_set;
    logic [2*DATA_W-1:0] w_fifo_din;
    logic [2*DATA_W-1:0] w_fifo_dout;

    assign w_tick    = (r_div_cnt == DIV_LAST);
    assign w_fall    = w_tick && r_bck;
    assign w_bit_nxt = r_bit_cnt + 1'b1;
    assign w_load    = w_fall && (w_bit_nxt == BIT_LOAD);
    assign w_rd      = w_load && !w_empty;
    // Decimator keeps the strobe seen on phase 0 and drops the one on phase 1
    assign w_wr_req  = APDATA_VALID_i && (!downsample_2x_i || !r_phase);
    // A full FIFO still accepts when the frame load frees a slot this cycle
    assign w_wr      = w_wr_req && (!w_full || w_rd);
    assign w_ovf_set = w_wr_req && w_full && !w_rd;
    assign w_unf_set = w_load && w_empty && r_primed;
    assign w_fifo_din = {APSDATA_LEFT_i, APSDATA_RIGHT_i};

    i2s_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*DATA_W)
    ) u_fifo (
        .i_clk (AMCLK_i),
        .i_rst (ARST_i),
        .wr    (w_wr),
        .rd    (w_rd),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (FIFO_LEVEL_o)
    );

    // BCK divider: BCK toggles every time div_cnt wraps
    always_ff @(posedge AMCLK_i) begin
        if (ARST_i) begin
            r_div_cnt <= '0;
            r_bck     <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_bck     <= ~r_bck;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Bit counter, WS and DATA all advance on the BCK falling edge
    always_ff @(posedge AMCLK_i) begin
        if (ARST_i) begin
            r_bit_cnt <= BIT_RESET;
            r_ws      <= 1'b0;
            r_data    <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_ws      <= ws_for_bit(w_bit_nxt);
            r_data    <= data_for_bit(r_hold, w_bit_nxt);
        end
    end

    // Decimation phase follows every strobe; primed marks the first accepted write
    always_ff @(posedge AMCLK_i) begin
        if (ARST_i) begin
            r_phase  <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            if (APDATA_VALID_i) begin
                r_phase <= ~r_phase;
            end
            if (w_wr_req) begin
                r_primed <= 1'b1;
            end
        end
    end

    // Hold regs capture the FIFO head one cycle after the frame-load pop
    always_ff @(posedge AMCLK_i) begin
        if (ARST_i) begin
            r_pop_p1 <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_pop_p1 <= w_rd;
            if (r_pop_p1) begin
                r_hold <= stereo_t'(w_fifo_dout);
            end
        end
    end

    // Sticky status flags; a new event wins over a same-cycle clear
    always_ff @(posedge AMCLK_i) begin
        if (ARST_i) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (STATUS_CLR_i) begin
                r_underflow <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (STATUS_CLR_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign I2S_BCK     = r_bck;
    assign I2S_WS      = r_ws;
    assign I2S_DATA    = r_data;
    assign UNDERFLOW_o = r_underflow;
    assign OVERFLOW_o  = r_overflow;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer (BCK_DIV=4, FIFO_DEPTH=4).
// A serial monitor rebuilds each frame and compares it with a scoreboard queue
// that the stimulus fills; compile with I2S_TX_LJ_EN to check left-justified WS.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

    localparam int BCK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               arst = 1'b1;
    logic signed [23:0] in_l = '0;
    logic signed [23:0] in_r = '0;
    logic               in_vld = 1'b0;
    logic               in_ds = 1'b0;
    logic               in_clr = 1'b0;
    logic               bck;
    logic               ws;
    logic               sdata;
    logic [2:0]         level;
    logic               unf;
    logic               ovf;

    always #5 clk = ~clk;

    i2s_tx_serializer #(
        .BCK_DIV    (BCK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .AMCLK_i         (clk),
        .ARST_i          (arst),
        .APSDATA_LEFT_i  (in_l),
        .APSDATA_RIGHT_i (in_r),
        .APDATA_VALID_i  (in_vld),
        .downsample_2x_i (in_ds),
        .STATUS_CLR_i    (in_clr),
        .I2S_BCK         (bck),
        .I2S_WS          (ws),
        .I2S_DATA        (sdata),
        .FIFO_LEVEL_o    (level),
        .UNDERFLOW_o     (unf),
        .OVERFLOW_o      (ovf)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic ws_model(input int b);
`ifdef I2S_TX_LJ_EN
        return (b < 32);
`else
        return (b >= 31) && (b <= 62);
`endif
    endfunction

    // Scoreboard and serial monitor state
    logic [47:0] expq[$];
    logic [47:0] cur_exp;
    logic        primed;
    logic        exp_uf;
    int          bitm;
    logic        prev_bck;
    logic        seen_fall;
    logic        loaded;
    logic        frame_ok;
    logic [23:0] cap_l;
    logic [23:0] cap_r;
    int          n_loads = 0;

    // Monitor: own bit counter from BCK edges; pops the scoreboard at each frame load
    always @(negedge clk) begin
        if (arst) begin
            bitm      = 62;
            prev_bck  = 1'b0;
            seen_fall = 1'b0;
            loaded    = 1'b0;
            frame_ok  = 1'b0;
            cur_exp   = '0;
            primed    = 1'b0;
            exp_uf    = 1'b0;
            cap_l     = '0;
            cap_r     = '0;
            expq.delete();
        end else begin
            if (prev_bck && !bck) begin
                bitm      = (bitm + 1) % 64;
                seen_fall = 1'b1;
                if (bitm == 63) begin
                    loaded = 1'b1;
                    n_loads++;
                    if (expq.size() > 0) cur_exp = expq.pop_front();
                    else if (primed) exp_uf = 1'b1;
                end
            end else if (!prev_bck && bck) begin
                if (seen_fall) chk("ws_bit", ws, ws_model(bitm));
                if (bitm == 0) frame_ok = loaded;
                if (bitm < 24) cap_l[23-bitm] = sdata;
                else if (bitm >= 32 && bitm < 56) cap_r[55-bitm] = sdata;
                else chk("pad_zero", sdata, 1'b0);
                if (bitm == 55 && frame_ok) chk("frame_lr", {cap_l, cap_r}, cur_exp);
            end
            prev_bck = bck;
        end
    end

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        ds;
        logic        align;
        int          gap;
        logic        wr;
        logic [2:0]  lvl;
        logic        ovfx;
    } vec_t;

    vec_t tv[15];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        tick();
        arst = 1'b1;
        repeat (3) tick();
        arst = 1'b0;
    endtask

    task automatic wait_load(input string nm);
        int start;
        int c;
        start = n_loads;
        c = 0;
        while (n_loads == start && c < 700) begin
            tick();
            c++;
        end
        if (n_loads == start) begin
            total++;
            bad++;
            $display("FAIL %s: no frame load seen within %0d cycles", nm, c);
        end
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r, input logic ds, input logic clr);
        in_l   = l;
        in_r   = r;
        in_ds  = ds;
        in_vld = 1'b1;
        in_clr = clr;
        tick();
        in_vld = 1'b0;
        in_clr = 1'b0;
    endtask

    task automatic apply_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (tv[i].align) wait_load("align_load");
            repeat (tv[i].gap) tick();
            if (tv[i].wr) begin
                expq.push_back({tv[i].l, tv[i].r});
                primed = 1'b1;
            end
            strobe(tv[i].l, tv[i].r, tv[i].ds, 1'b0);
            @(negedge clk);
            chk($sformatf("level_row%0d", i), level, tv[i].lvl);
            chk($sformatf("overflow_row%0d", i), ovf, tv[i].ovfx);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Row table: single pair, 6-strobe burst into a 4-deep FIFO, 2x decimation
        tv[0]  = '{24'hABCDEF, 24'h123456, 1'b0, 1'b1, 50,  1'b1, 3'd1, 1'b0};
        tv[1]  = '{24'hA00001, 24'h500001, 1'b0, 1'b1, 20,  1'b1, 3'd1, 1'b0};
        tv[2]  = '{24'hA00002, 24'h500002, 1'b0, 1'b0, 0,   1'b1, 3'd2, 1'b0};
        tv[3]  = '{24'hA00003, 24'h500003, 1'b0, 1'b0, 0,   1'b1, 3'd3, 1'b0};
        tv[4]  = '{24'hA00004, 24'h500004, 1'b0, 1'b0, 0,   1'b1, 3'd4, 1'b0};
        tv[5]  = '{24'hA00005, 24'h500005, 1'b0, 1'b0, 0,   1'b0, 3'd4, 1'b1};
        tv[6]  = '{24'hA00006, 24'h500006, 1'b0, 1'b0, 0,   1'b0, 3'd4, 1'b1};
        for (int k = 1; k <= 8; k++) begin
            tv[6+k] = '{24'(k), 24'(-k), 1'b1, (k == 1), (k == 1) ? 100 : 255,
                        (k % 2 == 1), 3'd1, 1'b0};
        end

        // Reset state, first BCK rise, idle frames without underflow
        tick();
        arst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_bck", bck, 1'b0);
        chk("rst_ws", ws, 1'b0);
        chk("rst_data", sdata, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_unf", unf, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        #2;
        arst = 1'b0;
        @(negedge clk);
        c = 0;
        while (!bck && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("bck_first_rise_cycles", c, 4);
        tick();
        repeat (3) wait_load("idle_load");
        chk("idle_no_underflow", unf, 1'b0);

        // Single pair then idle
        do_reset();
        apply_rows(0, 0);
        wait_load("t1_load_a");
        wait_load("t1_load_b");

        // One pair then starvation: repeat and sticky underflow
        do_reset();
        wait_load("t3_align");
        repeat (40) tick();
        expq.push_back({24'h800001, 24'h00FF00});
        primed = 1'b1;
        strobe(24'h800001, 24'h00FF00, 1'b0, 1'b0);
        wait_load("t3_pop");
        chk("unf_after_pop", unf, 1'b0);
        wait_load("t3_empty1");
        chk("unf_first_empty", unf, exp_uf);
        chk("unf_first_empty_set", unf, 1'b1);
        wait_load("t3_empty2");
        chk("unf_sticky", unf, 1'b1);
        repeat (100) tick();
        in_clr = 1'b1;
        tick();
        in_clr = 1'b0;
        exp_uf = 1'b0;
        @(negedge clk);
        chk("unf_cleared", unf, 1'b0);
        tick();

        // Burst into full FIFO, overflow clear and set-wins, then drain
        do_reset();
        apply_rows(1, 6);
        in_clr = 1'b1;
        tick();
        in_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", ovf, 1'b0);
        tick();
        strobe(24'h0BAD00, 24'h0BAD11, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovf_set_wins", ovf, 1'b1);
        chk("level_still_full", level, 3'd4);
        tick();
        repeat (5) wait_load("t4_drain");
        chk("unf_after_drain", unf, exp_uf);
        chk("level_drained", level, 3'd0);

        // 2x decimation: odd samples only, FIFO never backs up
        do_reset();
        apply_rows(7, 14);
        wait_load("t5_flush_a");
        wait_load("t5_flush_b");

        // Reset in the middle of a frame discards FIFO and zeroes outputs
        do_reset();
        wait_load("t6_align");
        repeat (30) tick();
        strobe(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
        strobe(24'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b0);
        c = 0;
        while (bitm != 40 && c < 700) begin
            tick();
            c++;
        end
        chk("t6_reached_bit40", bitm, 40);
        chk("t6_level_before", level, 3'd2);
        arst = 1'b1;
        tick();
        arst = 1'b0;
        @(negedge clk);
        chk("t6_bck", bck, 1'b0);
        chk("t6_ws", ws, 1'b0);
        chk("t6_data", sdata, 1'b0);
        chk("t6_level", level, 3'd0);
        tick();
        wait_load("t6_after_a");
        wait_load("t6_after_b");
        chk("t6_no_underflow", unf, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
